exibidor_jogadas: RTL
=====================

Name: exibidor_jogadas

Overview:
Sequence presenter for the memory game. It is the producer side of the play-comparison path: it reads the stored jogadas (4-bit one-hot codes) from the sequence memory, from address 0 up to the current round limit. Each jogada is driven onto the LEDs for a fixed on-time, followed by a blank gap. When the last jogada has been shown, the block pulses fim so the control unit can hand over to the player-input and comparator path.

Parameters:
- TEMPO_ACESO, 500: clock cycles each jogada stays lit. Must be >= 1.
- TEMPO_APAGADO, 250: clock cycles of blank gap after each jogada. Must be >= 1.
- ADDR_W, 4: width of the memory address and of the round limit.

Ports:
- clock, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- iniciar, input, 1: start request, level-sampled; acted on only in OCIOSO.
- limite, input, ADDR_W: index of the last jogada to show (inclusive). Sampled only when a start is accepted.
- dado, input, 4: memory read data for endereco. Asynchronous read, valid in the same cycle.
- endereco, output, ADDR_W: memory read address (registered).
- leds, output, 4: displayed jogada (registered). 0 = blank.
- exibindo, output, 1: high while a presentation is in progress (registered).
- fim, output, 1: one-cycle pulse when the presentation completes (registered).

Behaviour:
- Reset (reset=1 at a rising edge):
  - state <= OCIOSO; endereco, leds, exibindo, fim and timer all <= 0.
  - Reset takes priority over every other condition.
- States: OCIOSO, CARREGA, ACESO, APAGADO, FIM.
- OCIOSO:
  - exibindo=0, leds=0.
  - If iniciar=1: lim_reg <= limite, endereco <= 0, timer <= 0, exibindo <= 1, go to CARREGA.
- CARREGA (1 cycle):
  - leds <= dado, taken verbatim with no one-hot check; 0000 displays as blank.
  - timer <= 0, go to ACESO.
- ACESO:
  - leds held.
  - timer increments each cycle.
  - When timer == TEMPO_ACESO-1: leds <= 0, timer <= 0, go to APAGADO.
- APAGADO:
  - timer increments each cycle.
  - When timer == TEMPO_APAGADO-1:
    - If endereco == lim_reg: exibindo <= 0, fim <= 1, go to FIM.
    - Else: endereco <= endereco+1, go to CARREGA.
- FIM (1 cycle):
  - fim <= 0, go to OCIOSO.
  - fim is therefore high for exactly one cycle.
- Timing:
  - leds are nonzero for exactly TEMPO_ACESO cycles per jogada and zero for exactly TEMPO_APAGADO cycles after it (plus the CARREGA cycle before the next jogada).
  - One jogada takes 1+TEMPO_ACESO+TEMPO_APAGADO cycles.
  - With start accepted at edge 0, fim rises after edge (lim_reg+1)*(1+TEMPO_ACESO+TEMPO_APAGADO).
- Timer width: enough bits to hold max(TEMPO_ACESO, TEMPO_APAGADO)-1.
- iniciar and limite are ignored outside OCIOSO; changing limite mid-presentation has no effect.
- endereco never exceeds lim_reg, so there is no wrap-around. limite = 2^ADDR_W-1 shows all entries.
- iniciar held high continuously: after FIM the block returns to OCIOSO and restarts on the next edge, i.e. one idle cycle between presentations.
- Reset mid-presentation: aborts with no fim pulse; the next start begins again at endereco 0.

Test Plan:
Common setup: TEMPO_ACESO=3, TEMPO_APAGADO=2, ADDR_W=4; memory contents 0:0001, 1:0010, 2:0100, 3:1000.
1. Apply reset for 2 cycles, iniciar=0 -> endereco=0, leds=0, exibindo=0, fim=0; outputs stay 0 for 10 further cycles.
2. iniciar=1 for one cycle with limite=0 -> leds=0001 for exactly 3 cycles, then 0 for 2 cycles; fim=1 for exactly one cycle, rising after edge 6; exibindo=1 from edge 0 until edge 6; endereco stays 0.
3. limite=3, single iniciar pulse ->
   - leds show 0001, 0010, 0100, 1000 in order, each for 3 cycles with 2-cycle gaps.
   - endereco steps 0, 1, 2, 3.
   - fim pulses once, after edge 24.
4. Start with limite=1, then drive limite=3 and iniciar=1 during ACESO of jogada 0 -> only 0001 and 0010 are shown, fim after edge 12, and no restart mid-run.
5. limite=3; assert reset for one cycle during ACESO of jogada 2 (leds=0100) -> next edge gives leds=0, endereco=0, exibindo=0, no fim pulse; a new iniciar shows 0001 first.
6. iniciar held at 1 with limite=0 -> the presentation repeats, with fim pulses 8 cycles apart (6 + FIM + OCIOSO); leds pattern identical each time.

Source files
------------

// File: rtl/exibidor_jogadas.sv
// Sequence presenter for the memory game: shows stored jogadas 0..limite on the
// LEDs, each lit for TEMPO_ACESO cycles followed by a TEMPO_APAGADO blank gap.
module exibidor_jogadas #(
  parameter int TEMPO_ACESO   = 500,
  parameter int TEMPO_APAGADO = 250,
  parameter int ADDR_W        = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [3:0]        dado,
  output logic [ADDR_W-1:0] endereco,
  output logic [3:0]        leds,
  output logic              exibindo,
  output logic              fim
);

  localparam int TMAX = (TEMPO_ACESO > TEMPO_APAGADO) ? TEMPO_ACESO : TEMPO_APAGADO;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] ULTIMO_ACESO   = TW'(TEMPO_ACESO - 1);
  localparam logic [TW-1:0] ULTIMO_APAGADO = TW'(TEMPO_APAGADO - 1);

  typedef enum logic [2:0] {OCIOSO, CARREGA, ACESO, APAGADO, FIM} estado_t;

  estado_t           estado, estado_n;
  logic [TW-1:0]     timer, timer_n;
  logic [ADDR_W-1:0] lim_reg, lim_reg_n;
  logic [ADDR_W-1:0] endereco_n;
  logic [3:0]        leds_n;
  logic              exibindo_n, fim_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= OCIOSO;
      timer    <= '0;
      endereco <= '0;
      leds     <= '0;
      exibindo <= 1'b0;
      fim      <= 1'b0;
    end else begin
      estado   <= estado_n;
      timer    <= timer_n;
      endereco <= endereco_n;
      leds     <= leds_n;
      exibindo <= exibindo_n;
      fim      <= fim_n;
    end
  end

  // The round limit is latched only at start, so it needs no reset value.
  always_ff @(posedge clock) begin
    lim_reg <= lim_reg_n;
  end

  always_comb begin
    estado_n   = estado;
    timer_n    = timer;
    lim_reg_n  = lim_reg;
    endereco_n = endereco;
    leds_n     = leds;
    exibindo_n = exibindo;
    fim_n      = fim;
    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          lim_reg_n  = limite;
          endereco_n = '0;
          timer_n    = '0;
          exibindo_n = 1'b1;
          estado_n   = CARREGA;
        end
      end
      CARREGA: begin
        leds_n   = dado;
        timer_n  = '0;
        estado_n = ACESO;
      end
      ACESO: begin
        timer_n = timer + 1'b1;
        if (timer == ULTIMO_ACESO) begin
          leds_n   = '0;
          timer_n  = '0;
          estado_n = APAGADO;
        end
      end
      APAGADO: begin
        timer_n = timer + 1'b1;
        if (timer == ULTIMO_APAGADO) begin
          if (endereco == lim_reg) begin
            exibindo_n = 1'b0;
            fim_n      = 1'b1;
            estado_n   = FIM;
          end else begin
            endereco_n = endereco + 1'b1;
            estado_n   = CARREGA;
          end
        end
      end
      FIM: begin
        fim_n    = 1'b0;
        estado_n = OCIOSO;
      end
      default: estado_n = OCIOSO;
    endcase
  end

endmodule
